// File: rtl/mips_pkg.sv
// Shared MIPS constants, instruction field layout and the J-format target helper.
// Imported by the fetch stage, and by any later stage that needs opcode decoding.
package mips_pkg;

    typedef logic [31:0] instr_t;

    localparam instr_t      NOP_INSTR  = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    localparam logic [5:0]  OPC_RTYPE  = 6'h00;
    localparam logic [5:0]  OPC_J      = 6'h02;
    localparam logic [5:0]  OPC_BEQ    = 6'h04;

    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 26;
    localparam int          OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int          TARGET_W   = 26;

    function automatic logic [OPCODE_W-1:0] opcode_of(instr_t instr);
        return OPCODE_W'(instr >> OPCODE_LSB);
    endfunction

    // J-format target: upper nibble of the delay-slot PC, 26-bit word index shifted to bytes.
    function automatic logic [31:0] jump_target(logic [31:0] pc_plus4, instr_t instr);
        logic [31:0] target_mask;
        target_mask = (32'd1 << TARGET_W) - 32'd1;
        return (pc_plus4 & 32'hF000_0000) | ((instr & target_mask) << 2);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and the rest of the core (hazard unit, control, imem, ID).
// No valid/ready handshake: every input is sampled on the rising clk edge; imem_rdata is a combinational read of imem_addr.
interface if_stage_if #(
    parameter int PC_WIDTH = 32
);
    logic                stall;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                jump;
    logic                if_flush;

    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_rdata;

    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         ifid_instr;
    logic [PC_WIDTH-1:0] ifid_pc_plus4;
    logic                ifid_valid;
    logic [31:0]         fetch_count;
    logic [15:0]         flush_count;

    // Fetch-stage side
    modport master (
        input  stall, branch_taken, branch_target, jump, if_flush, imem_rdata,
        output imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid,
               fetch_count, flush_count
    );

    // Environment side: hazard unit, control unit, instruction memory, decode
    modport slave (
        output stall, branch_taken, branch_target, jump, if_flush, imem_rdata,
        input  imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid,
               fetch_count, flush_count
    );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: stall > jump > taken branch > sequential.
// load_en_o is low only while stalled; the IF/ID register shares it.
module pc_next_sel #(
    parameter int PC_WIDTH = 32
) (
    input  logic                stall_i,
    input  logic                jump_i,
    input  logic                branch_taken_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [PC_WIDTH-1:0] pc_plus4_i,
    input  logic [PC_WIDTH-1:0] jump_target_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    output logic [PC_WIDTH-1:0] next_pc_o,
    output logic                load_en_o
);

    logic [PC_WIDTH-1:0] branch_aligned;

    // Branch targets are word aligned; the two low bits are discarded.
    assign branch_aligned = branch_target_i & ~PC_WIDTH'(3);

    always_comb begin
        next_pc_o = pc_plus4_i;
        load_en_o = 1'b1;
        if (stall_i) begin
            next_pc_o = pc_i;
            load_en_o = 1'b0;
        end else if (jump_i) begin
            next_pc_o = jump_target_i;
        end else if (branch_taken_i) begin
            next_pc_o = branch_aligned;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register and fetch/flush counters.
// imem_addr comes straight from the PC flop, so redirect/stall inputs never reach it combinationally.
module if_stage #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(mips_pkg::RESET_PC),
    parameter logic [31:0]         NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic       clk,
    input  logic       rst_n,
    if_stage_if.master bus
);
    import mips_pkg::*;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] jump_tgt;
    logic                load_en;

    logic [31:0]         ifid_instr_q, ifid_instr_d;
    logic [PC_WIDTH-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic                ifid_valid_q, ifid_valid_d;
    logic [31:0]         fetch_count_q, fetch_count_d;
    logic [15:0]         flush_count_q, flush_count_d;

    assign pc_plus4 = pc_q + PC_WIDTH'(4);

    // The jump sits in ID, so its target is built from the IF/ID copy, not the fetch PC.
    assign jump_tgt = PC_WIDTH'(jump_target(32'(ifid_pc_plus4_q), ifid_instr_q));

    pc_next_sel #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next_sel (
        .stall_i         (bus.stall),
        .jump_i          (bus.jump),
        .branch_taken_i  (bus.branch_taken),
        .pc_i            (pc_q),
        .pc_plus4_i      (pc_plus4),
        .jump_target_i   (jump_tgt),
        .branch_target_i (bus.branch_target),
        .next_pc_o       (pc_d),
        .load_en_o       (load_en)
    );

    always_comb begin
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_valid_d    = ifid_valid_q;
        fetch_count_d   = fetch_count_q;
        flush_count_d   = flush_count_q;
        if (load_en) begin
            if (bus.if_flush) begin
                ifid_instr_d    = NOP_INSTR;
                ifid_pc_plus4_d = '0;
                ifid_valid_d    = 1'b0;
                if (flush_count_q != 16'hFFFF) begin
                    flush_count_d = flush_count_q + 16'd1;
                end
            end else begin
                ifid_instr_d    = bus.imem_rdata;
                ifid_pc_plus4_d = pc_plus4;
                ifid_valid_d    = 1'b1;
                fetch_count_d   = fetch_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_plus4_q <= '0;
            ifid_valid_q    <= 1'b0;
            fetch_count_q   <= '0;
            flush_count_q   <= '0;
        end else begin
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_valid_q    <= ifid_valid_d;
            fetch_count_q   <= fetch_count_d;
            flush_count_q   <= flush_count_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.pc            = pc_q;
    assign bus.ifid_instr    = ifid_instr_q;
    assign bus.ifid_pc_plus4 = ifid_pc_plus4_q;
    assign bus.ifid_valid    = ifid_valid_q;
    assign bus.fetch_count   = fetch_count_q;
    assign bus.flush_count   = flush_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a cycle-by-cycle vector table from reset, then hand-written
// sequences for the jump upper-nibble case, PC wrap-around and asynchronous reset mid-run.
module tb_if_stage;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    if_stage_if #(.PC_WIDTH(32)) bus ();

    if_stage #(
        .PC_WIDTH  (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory model: a few fixed words, address-derived pattern elsewhere
    function automatic logic [31:0] imem_word(logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h2009_0007;
            32'h0000_0008: return 32'h0800_0040;  // j 0x100
            32'h0000_000C: return 32'h1111_1111;
            32'h0000_0100: return 32'h2222_0000;
            32'h0000_0104: return 32'h3333_0000;
            32'h0000_0200: return 32'h4444_0000;
            32'h7000_0000: return 32'h0800_0010;  // j 0x7000_0040
            default:       return 32'hC000_0000 | a;
        endcase
    endfunction

    always_comb bus.imem_rdata = imem_word(bus.imem_addr);

    // redirect without squash is a protocol error on the control side
    always @(posedge clk) begin
        if (rst_n && !bus.stall && (bus.jump || bus.branch_taken) && !bus.if_flush) begin
            n_fail = n_fail + 1;
            $display("FAIL protocol: redirect without if_flush at %0t", $time);
        end
    end

    // scoreboard helpers
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic [31:0] e_pc4, input logic e_valid,
                               input logic [31:0] e_fetch, input logic [15:0] e_flush);
        check({tag, ".pc"},        bus.pc,              e_pc);
        check({tag, ".imem_addr"}, bus.imem_addr,       e_pc);
        check({tag, ".instr"},     bus.ifid_instr,      e_instr);
        check({tag, ".pc4"},       bus.ifid_pc_plus4,   e_pc4);
        check({tag, ".valid"},     32'(bus.ifid_valid), 32'(e_valid));
        check({tag, ".fetch"},     bus.fetch_count,     e_fetch);
        check({tag, ".flush"},     32'(bus.flush_count), 32'(e_flush));
    endtask

    // driver
    task automatic drive(input logic st, input logic jp, input logic br, input logic fl,
                         input logic [31:0] bt);
        bus.stall         = st;
        bus.jump          = jp;
        bus.branch_taken  = br;
        bus.if_flush      = fl;
        bus.branch_target = bt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        jump;
        logic        br;
        logic        flush;
        logic [31:0] bt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [31:0] e_fetch;
        logic [15:0] e_flush;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic vec_t mk(logic st, logic jp, logic br, logic fl, logic [31:0] bt,
                                logic [31:0] pc, logic [31:0] ins, logic [31:0] p4,
                                logic v, logic [31:0] fc, logic [15:0] xc);
        vec_t r;
        r.stall = st; r.jump = jp; r.br = br; r.flush = fl; r.bt = bt;
        r.e_pc = pc; r.e_instr = ins; r.e_pc4 = p4; r.e_valid = v;
        r.e_fetch = fc; r.e_flush = xc;
        return r;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        //                st jp br fl  bt             pc             instr          pc4            v  fetch flush
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,        32'h0000_0004, 32'h2008_0005, 32'h0000_0004, 1, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,        32'h0000_0008, 32'h2009_0007, 32'h0000_0008, 1, 2, 0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,        32'h0000_000C, 32'h0800_0040, 32'h0000_000C, 1, 3, 0);
        vecs[3]  = mk(0, 1, 0, 1, 32'h0,        32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 3, 1);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,        32'h0000_0104, 32'h2222_0000, 32'h0000_0104, 1, 4, 1);
        vecs[5]  = mk(1, 1, 0, 1, 32'h0,        32'h0000_0104, 32'h2222_0000, 32'h0000_0104, 1, 4, 1);
        vecs[6]  = mk(1, 0, 0, 0, 32'h0,        32'h0000_0104, 32'h2222_0000, 32'h0000_0104, 1, 4, 1);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,        32'h0000_0108, 32'h3333_0000, 32'h0000_0108, 1, 5, 1);
        vecs[8]  = mk(0, 0, 1, 1, 32'h0000_0203, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 0, 5, 2);
        vecs[9]  = mk(0, 0, 0, 0, 32'h0,        32'h0000_0204, 32'h4444_0000, 32'h0000_0204, 1, 6, 2);
        vecs[10] = mk(0, 1, 1, 1, 32'h0000_0300, 32'h0110_0000, 32'h0000_0000, 32'h0000_0000, 0, 6, 3);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,        32'h0110_0004, 32'hC110_0000, 32'h0110_0004, 1, 7, 3);
        vecs[12] = mk(1, 1, 0, 1, 32'h0,        32'h0110_0004, 32'hC110_0000, 32'h0110_0004, 1, 7, 3);
        vecs[13] = mk(0, 1, 0, 1, 32'h0,        32'h0440_0000, 32'h0000_0000, 32'h0000_0000, 0, 7, 4);
        vecs[14] = mk(0, 0, 0, 0, 32'h0,        32'h0440_0004, 32'hC440_0000, 32'h0440_0004, 1, 8, 4);

        // reset state, held without any clock effect
        #12;
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].jump, vecs[i].br, vecs[i].flush, vecs[i].bt);
            step();
            check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                        vecs[i].e_valid, vecs[i].e_fetch, vecs[i].e_flush);
        end

        // jump target keeps the upper nibble of the delay-slot PC
        drive(0, 0, 1, 1, 32'h7000_0000);
        step();
        check_state("br7", 32'h7000_0000, 32'h0, 32'h0, 1'b0, 32'd8, 16'd5);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check_state("fetch7", 32'h7000_0004, 32'h0800_0010, 32'h7000_0004, 1'b1, 32'd9, 16'd5);
        drive(0, 1, 0, 1, 32'h0);
        step();
        check_state("jmp7", 32'h7000_0040, 32'h0, 32'h0, 1'b0, 32'd9, 16'd6);

        // PC wrap-around; branch target low bits are ignored
        drive(0, 0, 1, 1, 32'hFFFF_FFFF);
        step();
        check_state("brtop", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd9, 16'd7);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check_state("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'd10, 16'd7);

        // asynchronous reset in the middle of a stall with a pending redirect
        drive(1, 1, 0, 1, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 16'd0);
        drive(0, 0, 0, 0, 32'h0);
        #3;
        rst_n = 1'b1;
        step();
        check_state("post_rst", 32'h0000_0004, 32'h2008_0005, 32'h0000_0004, 1'b1, 32'd1, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 20000", $time);
        n_fail = n_fail + 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Holds the PC, addresses instruction memory and selects the next PC (sequential, branch or jump).
- Owns the IF/ID pipeline register that feeds decode and the control unit.
- Consumes the control unit's Jump and IF_flush outputs, the ID-stage branch resolution, and the load-use stall from hazard detection.

Parameters:
- PC_WIDTH, 32, width of the PC and instruction-memory address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  load-use hazard; freezes PC and IF/ID.
- branch_taken  in  1  beq in ID resolved taken (Branch & Comparator).
- branch_target  in  PC_WIDTH  ID-stage branch target (pc_plus4 + signext<<2).
- jump  in  1  Jump from the control unit for the instruction in ID.
- if_flush  in  1  IF_flush from the control unit; squash the instruction being fetched.
- imem_addr  out  PC_WIDTH  instruction-memory address (= pc).
- imem_rdata  in  32  instruction word; combinational read of imem_addr.
- pc  out  PC_WIDTH  current fetch PC.
- ifid_instr  out  32  registered instruction to ID.
- ifid_pc_plus4  out  PC_WIDTH  registered PC+4 of ifid_instr.
- ifid_valid  out  1  1 = ifid_instr is a real instruction; 0 = bubble.
- fetch_count  out  32  instructions accepted into IF/ID with valid=1.
- flush_count  out  16  cycles in which a fetched instruction was squashed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC, ifid_instr = NOP_INSTR, ifid_pc_plus4 = 0, ifid_valid = 0, counters = 0.
  - First fetch after deassertion reads RESET_PC; that instruction is in IF/ID after the next rising edge.
- pc_plus4 = pc + 4, modulo 2^PC_WIDTH; 0xFFFF_FFFC wraps to 0.
- Jump target = {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}, computed internally from IF/ID.
- branch_target[1:0] is forced to 00.
- Next-PC priority, evaluated each rising edge:
  1. stall=1: pc and all IF/ID registers hold. jump, branch_taken and if_flush are ignored, because the ID instruction is re-decoded next cycle.
  2. jump=1: pc <= jump target.
  3. branch_taken=1: pc <= branch_target. If jump and branch_taken are both 1, jump wins.
  4. Otherwise: pc <= pc_plus4.
- IF/ID update when stall=0:
  - if_flush=1: ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc_plus4 <= 0, flush_count += 1 (saturating at 16'hFFFF).
  - Else: ifid_instr <= imem_rdata, ifid_pc_plus4 <= pc_plus4, ifid_valid <= 1, fetch_count += 1 (wrapping).
- Single-cycle redirect penalty: exactly one bubble per taken branch or jump.
- jump or branch_taken without if_flush is still honoured (PC redirected) but no squash occurs; this is a protocol error. Bench assertion only, no RTL check.
- A flushed bubble in ID presents opcode 000000 with RegWrite to $0, so it is architecturally harmless.
- rst_n asserted mid-stall or mid-redirect: all state returns to reset values immediately; pending redirect is lost.
- No combinational path from stall/jump/branch_taken to imem_addr; imem_addr is the registered pc.

Decomposition:
- Shared package mips_pkg:
  - Constants: NOP_INSTR, RESET_PC, OPC_RTYPE, OPC_J, OPC_BEQ.
  - Field-slice widths: opcode[31:26], target[25:0].
- One sub-module, pc_next_sel: combinational priority mux (stall/jump/branch/seq) producing next_pc and a load enable.
- PC register, IF/ID register and counters live in if_stage.

Test Plan:
- Reset release, imem returns 0x20080005 at 0, 0x20090007 at 4: after edges 1 and 2 ifid_instr = 0x20080005 then 0x20090007, ifid_pc_plus4 = 4 then 8, pc = 8.
- stall=1 for 2 cycles at pc=0x10: pc stays 0x10, IF/ID unchanged, fetch_count unchanged; resumes at 0x14 after release.
- ID holds j 0x0000040 with ifid_pc_plus4=0x0000_0104, jump=if_flush=1: next pc = 0x0000_0100, ifid_valid=0, ifid_instr=0, flush_count=1.
- branch_taken=1, if_flush=1, branch_target=0x0000_0203: pc = 0x0000_0200 next cycle; one bubble, then target instruction valid.
- stall=1 with jump=1, if_flush=1 simultaneously: no redirect, no flush. Next cycle stall=0 with jump=1: redirect taken.
- pc=0xFFFF_FFFC, sequential fetch: pc wraps to 0x0000_0000 and ifid_pc_plus4 = 0. rst_n pulsed low mid-cycle: outputs reset immediately without waiting for a clock edge.
